// File: rtl/pkt_disassembler.sv
// pkt_disassembler
//   Splits a received 72-bit SpiNNaker packet (header [7:0], key [39:8],
//   payload [71:40]) into 32-bit event words for the processor stream.
//   Multicast packets (header[7:6]==0) produce the key word, followed by the
//   payload word when header[1] is set. All other packets are accepted and
//   discarded, and each discard is counted in a saturating 16-bit counter.
//
//   Optional feature: define PKT_DISASSEMBLER_PARITY_CHECK_EN to enable the
//   parity check. Multicast packets whose header^key(^payload) parity is not
//   odd are then discarded and counted like non-multicast packets.
//
// Ports
//   clk          : single clock (HSSL interface domain)
//   reset        : synchronous, active-high
//   pkt_data_in  : received packet
//   pkt_vld_in   : qualifies pkt_data_in
//   pkt_rdy_out  : packet accept, high only when idle and out of reset
//   evt_data_out : event word
//   evt_last_out : last word of the packet
//   evt_vld_out  : qualifies the event word
//   evt_rdy_in   : downstream ready
//   drop_cnt_out : count of discarded packets, saturating
module pkt_disassembler #(
  parameter int PACKET_BITS = 72
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] pkt_data_in,
  input  logic                   pkt_vld_in,
  output logic                   pkt_rdy_out,
  output logic [31:0]            evt_data_out,
  output logic                   evt_last_out,
  output logic                   evt_vld_out,
  input  logic                   evt_rdy_in,
  output logic [15:0]            drop_cnt_out
);

  typedef enum logic [1:0] {IDLE, KEY, PLD} state_t;

  state_t                 state;
  logic [PACKET_BITS-1:0] pkt_reg;

  logic [7:0]  in_hdr;
  logic [31:0] in_key;
  logic [31:0] in_pld;
  logic        mc_ok;
  logic        pkt_xfer;
  logic        evt_xfer;

  assign in_hdr = pkt_data_in[7:0];
  assign in_key = pkt_data_in[39:8];
  assign in_pld = pkt_data_in[71:40];

`ifdef PKT_DISASSEMBLER_PARITY_CHECK_EN
  // Payload only participates when the packet claims to carry one.
  logic par_odd;
  assign par_odd = ^{in_hdr, in_key, (in_hdr[1] ? in_pld : 32'h0)};
  assign mc_ok   = (in_hdr[7:6] == 2'b00) && par_odd;
`else
  logic unused_pld;
  assign unused_pld = ^in_pld;
  assign mc_ok      = (in_hdr[7:6] == 2'b00);
`endif

  // Ready is decoded from state alone; forced low during reset.
  assign pkt_rdy_out = (state == IDLE) && !reset;
  assign pkt_xfer    = pkt_vld_in && pkt_rdy_out;
  assign evt_xfer    = evt_vld_out && evt_rdy_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pkt_reg      <= '0;
      evt_data_out <= '0;
      evt_last_out <= 1'b0;
      evt_vld_out  <= 1'b0;
      drop_cnt_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_xfer) begin
            if (mc_ok) begin
              // Key word is loaded straight into the output register so it
              // is visible the cycle after acceptance.
              pkt_reg      <= pkt_data_in;
              evt_data_out <= in_key;
              evt_last_out <= ~in_hdr[1];
              evt_vld_out  <= 1'b1;
              state        <= KEY;
            end else if (drop_cnt_out != 16'hFFFF) begin
              drop_cnt_out <= drop_cnt_out + 16'd1;
            end
          end
        end
        KEY: begin
          if (evt_xfer) begin
            if (pkt_reg[1]) begin
              evt_data_out <= pkt_reg[71:40];
              evt_last_out <= 1'b1;
              state        <= PLD;
            end else begin
              evt_vld_out <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        PLD: begin
          if (evt_xfer) begin
            evt_vld_out <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          evt_vld_out <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pkt_disassembler.md
PKT_DISASSEMBLER -- requirements
Module: pkt_disassembler

Interface
REQ-001 The block SHALL have parameter PACKET_BITS, default 72, meaning received SpiNNaker packet width: header [7:0], key [39:8], payload [71:40].
REQ-002 The block SHALL have port clk, input, 1, the single clock for all logic (HSSL interface clock domain).
REQ-003 The block SHALL have port reset, input, 1, which is synchronous and active-high.
REQ-004 The block SHALL have port pkt_data_in, input, PACKET_BITS, the received packet from the HSSL interface.
REQ-005 The block SHALL have port pkt_vld_in, input, 1, which qualifies pkt_data_in.
REQ-006 The block SHALL have port pkt_rdy_out, output, 1, the packet accept handshake.
REQ-007 The block SHALL have port evt_data_out, output, 32, the event word sent to the processor subsystem stream.
REQ-008 The block SHALL have port evt_last_out, output, 1, which marks the last word of a packet.
REQ-009 The block SHALL have port evt_vld_out, output, 1, which qualifies the event word.
REQ-010 The block SHALL have port evt_rdy_in, input, 1, the downstream ready signal.
REQ-011 The block SHALL have port drop_cnt_out, output, 16, the count of discarded packets, saturating.

Function
REQ-012 A packet transfer SHALL occur on any clk edge where pkt_vld_in and pkt_rdy_out are both high; an event transfer SHALL occur on any edge where evt_vld_out and evt_rdy_in are both high.
REQ-013 The FSM SHALL have states IDLE, KEY and PLD; pkt_rdy_out SHALL be high only in IDLE (combinational from state, independent of pkt_vld_in).
REQ-014 In IDLE, on a packet transfer with header[7:6]==2'b00 (multicast), the packet SHALL be registered and the FSM SHALL go to KEY.
REQ-015 In KEY: evt_vld_out=1, evt_data_out=key, evt_last_out=~header[1]. On an event transfer the FSM SHALL go to PLD if header[1]=1, else to IDLE.
REQ-016 In PLD: evt_vld_out=1, evt_data_out=payload, evt_last_out=1. On an event transfer the FSM SHALL go to IDLE.
REQ-017 Latency SHALL be one cycle: a packet accepted at edge N gives the key word valid after edge N, so a single word is visible to downstream in the cycle after acceptance.
REQ-018 Throughput with evt_rdy_in held high SHALL be one packet per 2 cycles without payload and one packet per 3 cycles with payload (one idle cycle per packet).
REQ-019 evt_data_out and evt_last_out SHALL stay stable while evt_vld_out=1 and evt_rdy_in=0; evt_vld_out SHALL never drop without a transfer.
REQ-020 In IDLE, evt_vld_out SHALL be 0 and evt_data_out/evt_last_out SHALL hold their last values.
REQ-021 A non-multicast packet (header[7:6]!=2'b00) SHALL be accepted, SHALL produce no event, and SHALL leave the FSM in IDLE.
REQ-022 Each discarded packet SHALL increment drop_cnt_out by one in the cycle after acceptance.
REQ-023 drop_cnt_out SHALL saturate at 16'hFFFF and SHALL not wrap.
REQ-024 A payload flag header[1] SHALL be honoured only for multicast packets; payload bits of packets without the flag SHALL be ignored.

Reset
REQ-025 On reset=1 at a clk edge: state=IDLE, evt_vld_out=0, evt_data_out=0, evt_last_out=0, drop_cnt_out=0, packet register=0.
REQ-026 pkt_rdy_out SHALL be 0 while reset is high.
REQ-027 Reset asserted mid-packet (KEY or PLD) SHALL abandon the pending words without emitting them and without counting a drop.

Configuration
REQ-028 Macro PKT_DISASSEMBLER_PARITY_CHECK_EN, when defined, SHALL enable a parity check.
REQ-029 With the macro defined, a multicast packet SHALL be discarded as in REQ-021/REQ-022 when the XOR of header and key (plus payload if header[1]=1) is not 1 (odd parity).
REQ-030 Without the macro, parity SHALL be ignored and no parity logic SHALL be synthesized.

Verification
REQ-031 The bench SHALL cover: MC packet header=8'h00, key=32'hDEAD_BEEF, evt_rdy_in=1 -> one word 32'hDEADBEEF, last=1, valid one cycle after accept, then pkt_rdy_out=1.
REQ-032 The bench SHALL cover: MC packet with payload, key=32'h0000_0001, payload=32'h1234_5678 -> words 1 (last=0) then 32'h12345678 (last=1) on consecutive cycles.
REQ-033 The bench SHALL cover: evt_rdy_in=0 for 5 cycles during KEY -> word held stable, pkt_rdy_out=0 throughout, key then payload emitted after rdy rises.
REQ-034 The bench SHALL cover: 3 packets with header[7:6]=2'b10 -> no events, drop_cnt_out=3; preloaded count 16'hFFFF plus one drop -> stays 16'hFFFF.
REQ-035 The bench SHALL cover: reset asserted in PLD -> next cycle evt_vld_out=0, drop_cnt_out=0, pkt_rdy_out=1 after reset is released.
REQ-036 The bench SHALL cover, with PKT_DISASSEMBLER_PARITY_CHECK_EN: MC packet with even parity -> dropped, drop_cnt_out increments; same packet with bit 0 flipped -> forwarded.
